// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Build option HAZARD_PERF_CNT_EN (see top) adds event counters.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FAULT = 2'd3
   } hz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] LOAD_SRC_DEF = 2'b01;
   localparam logic [4:0] REG_ZERO     = 5'd0;

   localparam int INIT_W = 4;
   localparam int WAIT_W = 8;

   // A later stage can supply rs only if it writes a real register that matches.
   function automatic logic fwd_hit(input logic we, input logic [4:0] wa, input logic [4:0] rs);
      return we && (wa != REG_ZERO) && (wa == rs);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sequencer bundle: stage register info in, hold/bubble/forward controls out.
interface pipeline_hazard_ctrl_if;

   logic [4:0] rs1_ID, rs2_ID;
   logic [4:0] rs1_EX, rs2_EX;
   logic [4:0] writeAddress_EX;
   logic [1:0] resultSrc_EX;
   logic       PCSrc_EX;
   logic       regWrite_MEM;
   logic [4:0] writeAddress_MEM;
   logic       regWrite_WB;
   logic [4:0] writeAddress_WB;
   logic       memReq_MEM;
   logic       memReady;

   logic       stall_IF, stall_ID, stall_EX, stall_MEM;
   logic       flush_ID, flush_EX, flush_MEM, flush_WB;
   logic [1:0] forwardA_EX, forwardB_EX;
   logic       mem_fault;

   // Core side
   modport master (
      output rs1_ID, rs2_ID, rs1_EX, rs2_EX, writeAddress_EX, resultSrc_EX, PCSrc_EX,
             regWrite_MEM, writeAddress_MEM, regWrite_WB, writeAddress_WB,
             memReq_MEM, memReady,
      input  stall_IF, stall_ID, stall_EX, stall_MEM,
             flush_ID, flush_EX, flush_MEM, flush_WB,
             forwardA_EX, forwardB_EX, mem_fault
   );

   // Controller side
   modport slave (
      input  rs1_ID, rs2_ID, rs1_EX, rs2_EX, writeAddress_EX, resultSrc_EX, PCSrc_EX,
             regWrite_MEM, writeAddress_MEM, regWrite_WB, writeAddress_WB,
             memReq_MEM, memReady,
      output stall_IF, stall_ID, stall_EX, stall_MEM,
             flush_ID, flush_EX, flush_MEM, flush_WB,
             forwardA_EX, forwardB_EX, mem_fault
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Per-operand EX forwarding select; MEM result beats WB result, x0 never forwarded.
module hazard_forward_sel
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic       en,
   input  logic [4:0] rs_EX,
   input  logic       regWrite_MEM,
   input  logic [4:0] writeAddress_MEM,
   input  logic       regWrite_WB,
   input  logic [4:0] writeAddress_WB,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (en) begin
         if (fwd_hit(regWrite_MEM, writeAddress_MEM, rs_EX))
            fwd = FWD_MEM;
         else if (fwd_hit(regWrite_WB, writeAddress_WB, rs_EX))
            fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage core with post-reset purge and memory timeout.
// Define HAZARD_PERF_CNT_EN to add load-use / memory-wait / flush event counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int         INIT_FLUSH_CYCLES = 4,
   parameter int         MEM_TIMEOUT       = 64,
   parameter logic [1:0] LOAD_SRC          = LOAD_SRC_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   pipeline_hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]               loadUseCount,
   output logic [31:0]               memWaitCount,
   output logic [31:0]               flushCount
`endif
);

   hz_state_t           state, state_nxt;
   logic [INIT_W-1:0]   init_cnt, init_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt, wait_inc;
   logic                mem_busy, load_use, fwd_en, active;
   logic                ev_load_use, ev_flush;

   assign mem_busy = hz.memReq_MEM & ~hz.memReady;
   assign load_use = (hz.resultSrc_EX == LOAD_SRC) && (hz.writeAddress_EX != REG_ZERO) &&
                     ((hz.writeAddress_EX == hz.rs1_ID) || (hz.writeAddress_EX == hz.rs2_ID));
   assign wait_inc = wait_cnt + 1'b1;
   assign active   = (state == ST_RUN) || (state == ST_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      init_nxt     = init_cnt;
      wait_nxt     = wait_cnt;
      fwd_en       = 1'b0;
      ev_load_use  = 1'b0;
      ev_flush     = 1'b0;
      hz.stall_IF  = 1'b0;
      hz.stall_ID  = 1'b0;
      hz.stall_EX  = 1'b0;
      hz.stall_MEM = 1'b0;
      hz.flush_ID  = 1'b0;
      hz.flush_EX  = 1'b0;
      hz.flush_MEM = 1'b0;
      hz.flush_WB  = 1'b0;
      hz.mem_fault = 1'b0;
      case (state)
         ST_INIT: begin
            hz.stall_IF  = 1'b1;
            hz.flush_ID  = 1'b1;
            hz.flush_EX  = 1'b1;
            hz.flush_MEM = 1'b1;
            hz.flush_WB  = 1'b1;
            if (init_cnt == INIT_W'(INIT_FLUSH_CYCLES - 1)) begin
               init_nxt  = '0;
               state_nxt = ST_RUN;
            end else begin
               init_nxt  = init_cnt + 1'b1;
            end
         end
         ST_RUN, ST_WAIT: begin
            fwd_en = 1'b1;
            if (mem_busy) begin
               // Freeze dominates branch and load-use; only the WB register takes a bubble.
               hz.stall_IF  = 1'b1;
               hz.stall_ID  = 1'b1;
               hz.stall_EX  = 1'b1;
               hz.stall_MEM = 1'b1;
               hz.flush_WB  = 1'b1;
               wait_nxt     = wait_inc;
               state_nxt    = (wait_inc >= WAIT_W'(MEM_TIMEOUT)) ? ST_FAULT : ST_WAIT;
            end else begin
               wait_nxt  = '0;
               state_nxt = ST_RUN;
               if (hz.PCSrc_EX) begin
                  hz.flush_ID = 1'b1;
                  hz.flush_EX = 1'b1;
                  ev_flush    = 1'b1;
               end else if (load_use) begin
                  hz.stall_IF = 1'b1;
                  hz.stall_ID = 1'b1;
                  hz.flush_EX = 1'b1;
                  ev_load_use = 1'b1;
               end
            end
         end
         ST_FAULT: begin
            hz.mem_fault = 1'b1;
            hz.stall_IF  = 1'b1;
            hz.stall_ID  = 1'b1;
            hz.stall_EX  = 1'b1;
            hz.stall_MEM = 1'b1;
            hz.flush_WB  = 1'b1;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   hazard_forward_sel u_fwd_a (
      .en               (fwd_en),
      .rs_EX            (hz.rs1_EX),
      .regWrite_MEM     (hz.regWrite_MEM),
      .writeAddress_MEM (hz.writeAddress_MEM),
      .regWrite_WB      (hz.regWrite_WB),
      .writeAddress_WB  (hz.writeAddress_WB),
      .fwd              (hz.forwardA_EX)
   );

   hazard_forward_sel u_fwd_b (
      .en               (fwd_en),
      .rs_EX            (hz.rs2_EX),
      .regWrite_MEM     (hz.regWrite_MEM),
      .writeAddress_MEM (hz.writeAddress_MEM),
      .regWrite_WB      (hz.regWrite_WB),
      .writeAddress_WB  (hz.writeAddress_WB),
      .fwd              (hz.forwardB_EX)
   );

`ifdef HAZARD_PERF_CNT_EN
   // Saturating event counters, counted only while the pipeline is live.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loadUseCount <= '0;
         memWaitCount <= '0;
         flushCount   <= '0;
      end else if (active) begin
         if (ev_load_use && (loadUseCount != '1)) loadUseCount <= loadUseCount + 1'b1;
         if (mem_busy    && (memWaitCount != '1)) memWaitCount <= memWaitCount + 1'b1;
         if (ev_flush    && (flushCount   != '1)) flushCount   <= flushCount + 1'b1;
      end
   end
`else
   logic unused_ev;
   assign unused_ev = ^{active, ev_load_use, ev_flush};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default parameters).
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] lu_cnt, mw_cnt, fl_cnt;
   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .hz(hz),
      .loadUseCount(lu_cnt), .memWaitCount(mw_cnt), .flushCount(fl_cnt)
   );
`else
   pipeline_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`endif

   // {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_MEM, flush_WB}
   wire [7:0] ctrl = {hz.stall_IF, hz.stall_ID, hz.stall_EX, hz.stall_MEM,
                      hz.flush_ID, hz.flush_EX, hz.flush_MEM, hz.flush_WB};

   localparam logic [7:0] C_INIT   = 8'h8F;
   localparam logic [7:0] C_NONE   = 8'h00;
   localparam logic [7:0] C_LU     = 8'hC4;
   localparam logic [7:0] C_BR     = 8'h0C;
   localparam logic [7:0] C_FREEZE = 8'hF1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.rs1_ID = 5'd0; hz.rs2_ID = 5'd0; hz.rs1_EX = 5'd0; hz.rs2_EX = 5'd0;
      hz.writeAddress_EX = 5'd0; hz.resultSrc_EX = 2'b00; hz.PCSrc_EX = 1'b0;
      hz.regWrite_MEM = 1'b0; hz.writeAddress_MEM = 5'd0;
      hz.regWrite_WB = 1'b0; hz.writeAddress_WB = 5'd0;
      hz.memReq_MEM = 1'b0; hz.memReady = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      // Forwarding candidates present during reset must still yield 00
      hz.regWrite_MEM = 1'b1; hz.writeAddress_MEM = 5'd7; hz.rs1_EX = 5'd7;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", 32'(ctrl), 32'(C_INIT));
      chk("reset_fault", 32'(hz.mem_fault), 32'd0);
      chk("reset_fwdA", 32'(hz.forwardA_EX), 32'd0);
      idle();

      // 1: purge lasts exactly four cycles after release
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("init_c%0d", i), 32'(ctrl), 32'(C_INIT));
         tick();
      end
      chk("run_idle", 32'(ctrl), 32'(C_NONE));

      // 2: load-use
      hz.resultSrc_EX = 2'b01; hz.writeAddress_EX = 5'd5; hz.rs2_ID = 5'd5;
      #1 chk("lu_rs2", 32'(ctrl), 32'(C_LU));
      hz.rs2_ID = 5'd0; hz.rs1_ID = 5'd5;
      #1 chk("lu_rs1", 32'(ctrl), 32'(C_LU));
      hz.resultSrc_EX = 2'b00;
      #1 chk("lu_not_load", 32'(ctrl), 32'(C_NONE));
      hz.resultSrc_EX = 2'b01; hz.rs1_ID = 5'd0; hz.writeAddress_EX = 5'd0;
      #1 chk("lu_x0", 32'(ctrl), 32'(C_NONE));
      idle();

      // 3: forwarding priority and x0
      hz.regWrite_MEM = 1'b1; hz.writeAddress_MEM = 5'd7;
      hz.regWrite_WB = 1'b1; hz.writeAddress_WB = 5'd7;
      hz.rs1_EX = 5'd7; hz.rs2_EX = 5'd3;
      #1 chk("fwdA_mem", 32'(hz.forwardA_EX), 32'd2);
      chk("fwdB_none", 32'(hz.forwardB_EX), 32'd0);
      hz.regWrite_MEM = 1'b0; hz.rs2_EX = 5'd7;
      #1 chk("fwdA_wb", 32'(hz.forwardA_EX), 32'd1);
      chk("fwdB_wb", 32'(hz.forwardB_EX), 32'd1);
      hz.regWrite_MEM = 1'b1; hz.writeAddress_MEM = 5'd0; hz.writeAddress_WB = 5'd0;
      hz.rs1_EX = 5'd0; hz.rs2_EX = 5'd0;
      #1 chk("fwdA_x0", 32'(hz.forwardA_EX), 32'd0);
      chk("fwdB_x0", 32'(hz.forwardB_EX), 32'd0);
      idle();

      // 4: three busy cycles then ready; forwarding stays live during the freeze
      hz.memReq_MEM = 1'b1; hz.memReady = 1'b0;
      hz.regWrite_MEM = 1'b1; hz.writeAddress_MEM = 5'd9; hz.rs1_EX = 5'd9;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("freeze_c%0d", i), 32'(ctrl), 32'(C_FREEZE));
         chk($sformatf("freeze_fwd_c%0d", i), 32'(hz.forwardA_EX), 32'd2);
         tick();
      end
      hz.memReady = 1'b1;
      #1 chk("wait_ready", 32'(ctrl), 32'(C_NONE));
      tick();
      idle();
      #1 chk("back_run", 32'(ctrl), 32'(C_NONE));

      // 5: branch beats load-use; freeze beats branch
      hz.resultSrc_EX = 2'b01; hz.writeAddress_EX = 5'd4; hz.rs1_ID = 5'd4; hz.PCSrc_EX = 1'b1;
      #1 chk("br_over_lu", 32'(ctrl), 32'(C_BR));
      hz.memReq_MEM = 1'b1;
      #1 chk("freeze_over_br", 32'(ctrl), 32'(C_FREEZE));
      tick();
      hz.memReady = 1'b1;
      #1 chk("wait_ready_br", 32'(ctrl), 32'(C_BR));
      tick();
      idle();

      // 6: timeout after exactly 64 busy cycles (wait counter was cleared above)
      hz.memReq_MEM = 1'b1; hz.memReady = 1'b0;
      #1 chk("to_start", 32'(ctrl), 32'(C_FREEZE));
      repeat (63) tick();
      chk("to_63_nofault", 32'(hz.mem_fault), 32'd0);
      tick();
      chk("to_64_fault", 32'(hz.mem_fault), 32'd1);
      chk("fault_ctrl", 32'(ctrl), 32'(C_FREEZE));
      hz.memReady = 1'b1;
      hz.regWrite_MEM = 1'b1; hz.writeAddress_MEM = 5'd3; hz.rs1_EX = 5'd3;
      tick();
      chk("fault_sticky", 32'(hz.mem_fault), 32'd1);
      chk("fault_ctrl_sticky", 32'(ctrl), 32'(C_FREEZE));
      chk("fault_fwd", 32'(hz.forwardA_EX), 32'd0);
      idle();
      #2 rst_n = 1'b0;
      #1 chk("rst_fault_clr", 32'(hz.mem_fault), 32'd0);
      chk("rst_ctrl", 32'(ctrl), 32'(C_INIT));
      tick();
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reinit_c%0d", i), 32'(ctrl), 32'(C_INIT));
         tick();
      end
      chk("rerun_idle", 32'(ctrl), 32'(C_NONE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
